// File: rtl/eth_frame_reflector.sv
// Ethernet frame reflector: captures the 12-byte MAC header, optionally filters on
// destination, re-emits (or swaps) the header, then streams the rest of the frame through.
module eth_frame_reflector #(
  parameter string       MODE         = "SWAP",
  parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
  parameter bit          FILTER_EN    = 1'b1,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int          COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_tdata,
  input  logic                   rx_tvalid,
  output logic                   rx_tready,
  input  logic                   rx_tlast,
  input  logic                   rx_tuser,
  output logic [7:0]             tx_tdata,
  output logic                   tx_tvalid,
  input  logic                   tx_tready,
  output logic                   tx_tlast,
  output logic                   tx_tuser,
  input  logic                   cfg_enable,
  output logic [COUNT_WIDTH-1:0] cnt_fwd,
  output logic [COUNT_WIDTH-1:0] cnt_filtered,
  output logic [COUNT_WIDTH-1:0] cnt_runt
);

  localparam bit SWAP_MODE = (MODE == "SWAP");
  // Element 5 holds byte 0 (first on the wire).
  localparam logic [5:0][7:0] LMAC = LOCAL_MAC;

  typedef enum logic [1:0] {CAPTURE, EMIT, STREAM, DROP} state_t;

  state_t           state;
  logic [3:0]       idx;
  logic [11:0][7:0] hdr;
  logic             en_lat;
  logic [7:0]       emit_byte;
  logic [7:0]       emit_next;
  logic [3:0]       k;
  logic [2:0]       j;
  logic [47:0]      dst;
  logic             reject;
  logic             rx_fire;
  logic             tx_fire;

  assign rx_fire = rx_tvalid & rx_tready;
  assign tx_fire = tx_tvalid & tx_tready;
  assign dst     = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]};
  assign reject  = !en_lat ||
                   (FILTER_EN && !((dst == LOCAL_MAC) || (ACCEPT_BCAST && (dst == '1))));

  // Next header byte to present: byte 0 on entry to EMIT, idx+1 while emitting.
  always_comb begin
    k = 4'd0;
    if (state == EMIT) k = (idx == 4'd11) ? 4'd11 : idx + 4'd1;
    j = 3'(k - 4'd6);
    emit_next = hdr[k];
    if (SWAP_MODE) begin
      if (k < 4'd6) emit_next = hdr[k + 4'd6];
      else          emit_next = LMAC[3'd5 - j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CAPTURE;
      idx          <= 4'd0;
      en_lat       <= 1'b0;
      emit_byte    <= 8'd0;
      cnt_fwd      <= '0;
      cnt_filtered <= '0;
      cnt_runt     <= '0;
    end else begin
      case (state)
        CAPTURE: if (rx_fire) begin
          hdr[idx] <= rx_tdata;
          if (idx == 4'd0) en_lat <= cfg_enable;
          if (rx_tlast) begin
            cnt_runt <= cnt_runt + COUNT_WIDTH'(1);
            idx      <= 4'd0;
          end else if (idx == 4'd11) begin
            idx <= 4'd0;
            // Byte 11 is not yet in hdr, but neither dst nor the first emitted byte needs it.
            if (reject) begin
              state        <= DROP;
              cnt_filtered <= cnt_filtered + COUNT_WIDTH'(1);
            end else begin
              state     <= EMIT;
              emit_byte <= emit_next;
            end
          end else begin
            idx <= idx + 4'd1;
          end
        end
        EMIT: if (tx_fire) begin
          if (idx == 4'd11) begin
            state <= STREAM;
            idx   <= 4'd0;
          end else begin
            idx       <= idx + 4'd1;
            emit_byte <= emit_next;
          end
        end
        STREAM: if (rx_fire && rx_tlast) begin
          cnt_fwd <= cnt_fwd + COUNT_WIDTH'(1);
          state   <= CAPTURE;
        end
        DROP: if (rx_fire && rx_tlast) state <= CAPTURE;
        default: state <= CAPTURE;
      endcase
    end
  end

  always_comb begin
    rx_tready = 1'b0;
    tx_tvalid = 1'b0;
    tx_tdata  = emit_byte;
    tx_tlast  = 1'b0;
    tx_tuser  = 1'b0;
    if (!reset) begin
      case (state)
        CAPTURE, DROP: rx_tready = 1'b1;
        EMIT:          tx_tvalid = 1'b1;
        STREAM: begin
          tx_tdata  = rx_tdata;
          tx_tvalid = rx_tvalid;
          tx_tlast  = rx_tlast;
          tx_tuser  = rx_tuser;
          rx_tready = tx_tready;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_reflector.sv
// Scoreboard bench for eth_frame_reflector: driver pushes expected tx bytes, monitor pops on tx handshakes.
module tb_eth_frame_reflector;

  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid, rx_tready, rx_tlast, rx_tuser;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid, tx_tready, tx_tlast, tx_tuser;
  logic        cfg_enable;
  logic [31:0] cnt_fwd, cnt_filtered, cnt_runt;

  typedef struct packed {logic [7:0] d; logic l; logic u;} ent_t;
  ent_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   rnd   = 0;

  eth_frame_reflector dut (
    .clk(clk), .reset(reset),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
    .cfg_enable(cfg_enable),
    .cnt_fwd(cnt_fwd), .cnt_filtered(cnt_filtered), .cnt_runt(cnt_runt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Inputs only change at posedge+1, so a handshake seen at negedge completes at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx_tvalid && tx_tready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected: got %0h/%0b/%0b want nothing", tx_tdata, tx_tlast, tx_tuser);
        end else begin
          ent_t e;
          e = q.pop_front();
          if ({tx_tdata, tx_tlast, tx_tuser} !== e) begin
            bad++;
            $display("FAIL tx_byte: got %0h/%0b/%0b want %0h/%0b/%0b",
                     tx_tdata, tx_tlast, tx_tuser, e.d, e.l, e.u);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      tx_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit l, input bit u);
    int n;
    if (rnd) while ($urandom_range(0, 9) >= 7) begin
      rx_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    rx_tvalid = 1'b1; rx_tdata = d; rx_tlast = l; rx_tuser = u;
    n = 0;
    forever begin
      @(negedge clk);
      if (rx_tready) break;
      n++;
      if (n > 2000) begin
        total++; bad++;
        $display("FAIL rx_stall: got tready=0 for %0d cycles want handshake", n);
        break;
      end
    end
    @(posedge clk); #1;
    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
  endtask

  function automatic logic [7:0] mac_byte(input logic [47:0] m, input int i);
    return m[47-8*i -: 8];
  endfunction

  // Frame: dst, src, then payload byte i = i. Sends the first 'stop' bytes only.
  task automatic run_frame(input logic [47:0] dst, input logic [47:0] src, input int len,
                           input bit u, input bit fwd, input int stop);
    logic [7:0] b, e;
    bit         last;
    for (int i = 0; i < len && i < stop; i++) begin
      if (i < 6)       e = mac_byte(src, i);
      else if (i < 12) e = mac_byte(LOCAL, i - 6);
      else             e = 8'(i);
      last = (i == len - 1);
      if (fwd) q.push_back({e, last, u & last});
    end
    for (int i = 0; i < len && i < stop; i++) begin
      if (i < 6)       b = mac_byte(dst, i);
      else if (i < 12) b = mac_byte(src, i - 6);
      else             b = 8'(i);
      last = (i == len - 1);
      send_byte(b, last, u & last);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain_left", 64'(q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int f, input int d, input int r);
    chk({tag, "_fwd"}, 64'(cnt_fwd), 64'(f));
    chk({tag, "_filt"}, 64'(cnt_filtered), 64'(d));
    chk({tag, "_runt"}, 64'(cnt_runt), 64'(r));
  endtask

  initial begin
    reset = 1'b1; rx_tvalid = 1'b0; rx_tdata = 8'd0; rx_tlast = 1'b0; rx_tuser = 1'b0;
    tx_tready = 1'b1; cfg_enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_tready", 64'(rx_tready), 64'd0);
    chk("rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_cnt("reset", 0, 0, 0);
    chk("idle_rx_tready", 64'(rx_tready), 64'd1);
    @(posedge clk); #1;

    // Swap of a 64-byte unicast frame
    run_frame(LOCAL, 48'h0A_0B_0C_0D_0E_0F, 64, 0, 1, 64);
    drain();
    chk_cnt("s1", 1, 0, 0);

    // Foreign dst filtered, then a local frame straight after
    run_frame(48'h00_11_22_33_44_55, 48'h0A_0B_0C_0D_0E_0F, 64, 0, 0, 64);
    run_frame(LOCAL, 48'h12_34_56_78_9A_BC, 64, 0, 1, 64);
    drain();
    chk_cnt("s2", 2, 1, 0);

    // Broadcast accepted, then dropped with cfg_enable low
    run_frame(48'hFF_FF_FF_FF_FF_FF, 48'h0A_0B_0C_0D_0E_0F, 60, 0, 1, 60);
    cfg_enable = 1'b0;
    run_frame(48'hFF_FF_FF_FF_FF_FF, 48'h0A_0B_0C_0D_0E_0F, 60, 0, 0, 60);
    cfg_enable = 1'b1;
    drain();
    chk_cnt("s3", 3, 2, 0);

    // Runts of 8 and 12 bytes, then a normal 60-byte frame
    run_frame(LOCAL, 48'h0A_0B_0C_0D_0E_0F, 8, 0, 0, 8);
    run_frame(LOCAL, 48'h0A_0B_0C_0D_0E_0F, 12, 0, 0, 12);
    run_frame(LOCAL, 48'h22_33_44_55_66_77, 60, 0, 1, 60);
    drain();
    chk_cnt("s4", 4, 2, 2);

    // Random backpressure and gaps, bad-frame flag on tlast
    rnd = 1;
    run_frame(LOCAL, 48'hA0_A1_A2_A3_A4_A5, 200, 1, 1, 200);
    drain();
    rnd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt("s5", 5, 2, 2);

    // Reset while byte 30 of a streaming frame is presented
    run_frame(LOCAL, 48'h0A_0B_0C_0D_0E_0F, 64, 0, 1, 30);
    rx_tvalid = 1'b1; rx_tdata = 8'd30; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rx_tvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_tvalid", 64'(tx_tvalid), 64'd0);
    chk_cnt("post_rst", 0, 0, 0);
    chk("post_rst_q", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    run_frame(LOCAL, 48'h0A_0B_0C_0D_0E_0F, 64, 0, 1, 64);
    drain();
    chk_cnt("s6", 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/eth_frame_reflector.md
Name: eth_frame_reflector

Overview:
- Parametrised successor to the fixed MAC-level loopback. It sits between the RX and TX AXI-Stream ports of eth_mac_mii_fifo_wrapper.
- Buffers each frame's 12-byte MAC header and optionally filters on destination MAC. In SWAP mode it rewrites the header (dst = received src, src = LOCAL_MAC). Payload and FCS-stripped tail stream through unmodified.
- Provides per-class frame counters for bring-up and link test.

Parameters:
- MODE, "SWAP", "SWAP" rewrites header as above; "PASS" re-emits captured header unchanged.
- LOCAL_MAC, 48'h02_00_00_00_00_01, station address. Byte 0 = bits [47:40], first on the wire.
- FILTER_EN, 1, 1 = drop frames whose dst is neither LOCAL_MAC nor accepted broadcast; 0 = accept all.
- ACCEPT_BCAST, 1, 1 = dst FF:FF:FF:FF:FF:FF passes the filter.
- COUNT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- rx_axis_if  AXIS_IF.Receiver  -  frames from MAC RX FIFO: tdata 8 bit, tvalid, tready, tlast, tuser 1 bit (bad frame).
- tx_axis_if  AXIS_IF.Transmitter  -  frames to MAC TX FIFO, same signal set.
- cfg_enable  input  1  sampled at frame start. 0 = the whole frame is dropped and counted as filtered.
- cnt_fwd  output  COUNT_WIDTH  frames fully forwarded.
- cnt_filtered  output  COUNT_WIDTH  frames dropped by filter or cfg_enable.
- cnt_runt  output  COUNT_WIDTH  frames ending within the first 12 bytes.

Behaviour:
- Interfaces: one clock; reset synchronous, active-high. AXIS_IF instances must be 8-bit tdata, 1-bit tuser. Transfer occurs when tvalid & tready are both high on a clk rising edge.
- Reset values: state CAPTURE, byte index 0, all counters 0. tx tvalid, tlast and tuser are 0; tx tdata is don't-care. rx tready is forced 0 while reset is high.
- Reset mid-frame aborts the frame without emitting tlast. The next accepted rx byte is treated as byte 0 of a new frame.
- State CAPTURE:
  - rx tready=1, tx tvalid=0.
  - Each accepted byte is stored in hdr[idx] and idx increments.
  - cfg_enable is latched on the idx=0 byte.
  - tlast accepted with idx<=11: runt. cnt_runt+1, idx→0, stay in CAPTURE, no output. A frame with tlast on byte 11 is a runt (no EtherType).
  - Byte 11 accepted without tlast, frame rejected → DROP, cnt_filtered+1. Rejected means latched cfg_enable=0, or FILTER_EN=1 and dst (hdr[0..5]) is neither LOCAL_MAC nor (ACCEPT_BCAST=1 and dst=all-ones).
  - Otherwise → EMIT.
- State EMIT:
  - rx tready=0, tx tvalid=1, tlast=0, tuser=0.
  - Outputs 12 header bytes in order, advancing on each tx handshake.
  - SWAP mode: hdr[6..11] first, then LOCAL_MAC bytes 0..5. PASS mode: hdr[0..11].
  - Registered output: first header byte is valid the cycle after the byte-11 accept, so latency is 1 cycle.
  - After header byte 11 handshakes → STREAM.
- State STREAM:
  - Combinational pass-through: tx tdata/tvalid/tlast/tuser = rx; rx tready = tx tready. Zero added latency, full throughput.
  - tlast handshake: cnt_fwd+1, → CAPTURE idx=0. A bad-frame tuser is propagated with tlast so the TX FIFO discards the frame.
- State DROP:
  - rx tready=1, tx tvalid=0.
  - tlast accepted → CAPTURE.
- Counters wrap modulo 2^COUNT_WIDTH and update the cycle after the qualifying handshake. At most one counter increments per cycle.
- Per-frame overhead is 12 stall cycles on rx during EMIT. No frame reordering; one frame in flight.
- Implementation estimate: 150-250 lines, FSM plus 12x8 header register.

Test Plan:
- SWAP, 64-byte frame, dst=02:00:00:00:00:01, src=0A:0B:0C:0D:0E:0F, payload bytes = index → output bytes 0-5 = 0A..0F, 6-11 = 02:00:00:00:00:01, 12..63 identical to input; tlast on byte 63; cnt_fwd=1.
- FILTER_EN=1, dst=00:11:22:33:44:55 → no tx tvalid for the whole frame; cnt_filtered=1. An immediately following dst=LOCAL_MAC frame is forwarded intact; cnt_fwd=1.
- Broadcast dst FF:FF:FF:FF:FF:FF with ACCEPT_BCAST=1 → forwarded. Repeat with cfg_enable=0 → dropped, cnt_filtered+1.
- 8-byte frame and 12-byte frame (tlast on byte 11) → no output; cnt_runt=2; next 60-byte frame forwarded correctly.
- 200-byte frame with tuser=1 on last byte, tx tready random 50%, rx tvalid random 70% → byte-exact output, tuser=1 only with tlast, no lost or duplicated bytes.
- Reset pulse (1 cycle) while STREAM at byte 30 → tx tvalid=0 the cycle after reset, all counters 0. Next complete frame processed as in scenario 1.
